// File: rtl/seg_clock_monitor.sv
// Seconds-display checker: filters and decodes two 7-segment buses, then verifies
// that the shown value advances by +1 mod 60 per change and flags stalls.
module seg_clock_monitor #(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 60_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_units,
    input  logic [6:0] seg_tens,
    input  logic       clr_err,
    output logic [3:0] units,
    output logic [2:0] tens,
    output logic       value_valid,
    output logic       step_ok,
    output logic       err_pattern,
    output logic       err_sequence,
    output logic       err_timeout
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StAcquire, StTrack} state_e;

    state_e        state_q, state_d;
    logic [13:0]   in_q, in_d;
    logic [13:0]   seen_pat_q, seen_pat_d;
    logic          seen_q, seen_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    units_q, units_d;
    logic [2:0]    tens_q, tens_d;
    logic          step_ok_q, step_ok_d;
    logic          err_pat_q, err_pat_d;
    logic          err_seq_q, err_seq_d;
    logic          err_tmo_q, err_tmo_d;

    // Returns {legal, digit}; alternate forms of 6, 7 and 9 are both accepted.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111:              decode = {1'b1, 4'd0};
            7'b0000110:              decode = {1'b1, 4'd1};
            7'b1011011:              decode = {1'b1, 4'd2};
            7'b1001111:              decode = {1'b1, 4'd3};
            7'b1100110:              decode = {1'b1, 4'd4};
            7'b1101101:              decode = {1'b1, 4'd5};
            7'b1111101, 7'b1111100:  decode = {1'b1, 4'd6};
            7'b0000111, 7'b0100111:  decode = {1'b1, 4'd7};
            7'b1111111:              decode = {1'b1, 4'd8};
            7'b1101111, 7'b1100111:  decode = {1'b1, 4'd9};
            default:                 decode = 5'b0_0000;
        endcase
    endfunction

    logic [4:0] u_dec, t_dec;
    logic       pair_legal, stable, evaluate;
    logic [5:0] new_val, old_val, exp_val;
    logic       pat_set, seq_set, tmo_set;

    always_comb begin
        in_d = SEG_ACTIVE_LOW ? ~{seg_tens, seg_units} : {seg_tens, seg_units};

        if (in_d != in_q) begin
            stab_d = SW'(1);
        end else if (stab_q < SW'(STABLE_CYCLES)) begin
            stab_d = stab_q + SW'(1);
        end else begin
            stab_d = stab_q;
        end

        u_dec      = decode(in_q[6:0]);
        t_dec      = decode(in_q[13:7]);
        pair_legal = u_dec[4] & t_dec[4] & (t_dec[3:0] <= 4'd5);
        new_val    = 6'(t_dec[3:0]) * 6'd10 + 6'(u_dec[3:0]);
        old_val    = 6'(tens_q) * 6'd10 + 6'(units_q);
        exp_val    = (old_val == 6'd59) ? 6'd0 : old_val + 6'd1;

        // A pattern is judged once: remember the last one evaluated.
        stable   = (stab_q == SW'(STABLE_CYCLES)) && (!seen_q || (in_q != seen_pat_q));
        evaluate = stable && (state_q != StIdle);

        state_d    = state_q;
        seen_d     = seen_q;
        seen_pat_d = seen_pat_q;
        tmo_d      = '0;
        units_d    = units_q;
        tens_d     = tens_q;
        step_ok_d  = 1'b0;
        pat_set    = 1'b0;
        seq_set    = 1'b0;
        tmo_set    = 1'b0;

        if (evaluate) begin
            seen_d     = 1'b1;
            seen_pat_d = in_q;
        end

        case (state_q)
            StIdle: state_d = StAcquire;
            StAcquire: begin
                if (evaluate) begin
                    if (pair_legal) begin
                        units_d = u_dec[3:0];
                        tens_d  = t_dec[2:0];
                        state_d = StTrack;
                    end else begin
                        pat_set = 1'b1;
                    end
                end
            end
            StTrack: begin
                if (evaluate && pair_legal) begin
                    units_d = u_dec[3:0];
                    tens_d  = t_dec[2:0];
                    if (new_val == exp_val) begin
                        step_ok_d = 1'b1;
                    end else begin
                        seq_set = 1'b1;
                    end
                end else if (evaluate) begin
                    pat_set = 1'b1;
                    state_d = StAcquire;
                end else if (tmo_q < TW'(TIMEOUT_CYCLES)) begin
                    tmo_d   = tmo_q + TW'(1);
                    tmo_set = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
                end else begin
                    tmo_d = tmo_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // A newly detected error beats a simultaneous clear.
        err_pat_d = pat_set | (err_pat_q & ~clr_err);
        err_seq_d = seq_set | (err_seq_q & ~clr_err);
        err_tmo_d = tmo_set | (err_tmo_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            in_q       <= '0;
            seen_pat_q <= '0;
            seen_q     <= 1'b0;
            stab_q     <= '0;
            tmo_q      <= '0;
            units_q    <= '0;
            tens_q     <= '0;
            step_ok_q  <= 1'b0;
            err_pat_q  <= 1'b0;
            err_seq_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            seen_pat_q <= seen_pat_d;
            seen_q     <= seen_d;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            units_q    <= units_d;
            tens_q     <= tens_d;
            step_ok_q  <= step_ok_d;
            err_pat_q  <= err_pat_d;
            err_seq_q  <= err_seq_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign units        = units_q;
    assign tens         = tens_q;
    assign value_valid  = (state_q == StTrack);
    assign step_ok      = step_ok_q;
    assign err_pattern  = err_pat_q;
    assign err_sequence = err_seq_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: doc/seg_clock_monitor.md
# seg_clock_monitor

Checker for the two-digit seconds display bus (units digit 0–9, tens digit 0–5, wrapping 59→00). It samples the two raw 7-segment buses, filters glitches, decodes the patterns back to BCD, and checks that the displayed value advances exactly +1 mod 60 per change. It also flags stalls. It sits beside the display outputs on the board top and drives LEDs/debug taps.

## Interface
- `SEG_ACTIVE_LOW`, default 1: 1 = a lit segment is driven 0 on the inputs; inputs are inverted before decode.
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a pattern is accepted (≥1).
- `TIMEOUT_CYCLES`, default 60_000_000: maximum number of cycles allowed between accepted changes while tracking (≥2).
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `seg_units  in  7`: units-digit segments, bit0 = a … bit6 = g.
- `seg_tens  in  7`: tens-digit segments, same bit order.
- `clr_err  in  1`: synchronous clear of all sticky error flags.
- `units  out  4`: last accepted units value (BCD).
- `tens  out  3`: last accepted tens value.
- `value_valid  out  1`: high while in TRACK.
- `step_ok  out  1`: one-cycle pulse on each correct +1 step.
- `err_pattern  out  1`: sticky; a stable pattern was not a legal digit.
- `err_sequence  out  1`: sticky; an accepted change was not +1 mod 60.
- `err_timeout  out  1`: sticky; no change occurred within TIMEOUT_CYCLES.

## Operation
- Input stage: `{seg_tens, seg_units}` is registered every cycle into `in_q`. The inversion selected by `SEG_ACTIVE_LOW` is applied here.
- Stability filter: a counter counts consecutive cycles in which `in_q` is unchanged. It resets to 1 when `in_q` differs from the previous sample and saturates at STABLE_CYCLES. A pattern is "stable" when the count equals STABLE_CYCLES and the pattern differs from the last accepted pattern. Each such pattern is evaluated exactly once.
- Decode (gfedcba, lit = 1):
  - Legal patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101.
  - 6 = 1111101 or 1111100 (both forms accepted).
  - 7 = 0000111 or 0100111 (both forms accepted).
  - 8 = 1111111.
  - 9 = 1101111 or 1100111 (both forms accepted).
  - The tens digit is legal only for 0–5. Any other pattern is illegal, including all-dark.
- FSM states: IDLE, ACQUIRE, TRACK.
  - IDLE → ACQUIRE on the first cycle after reset release.
  - ACQUIRE: on a stable legal pair, load `units`/`tens` and go to TRACK. No step check is made on this first value. On a stable illegal pair, set `err_pattern` and stay in ACQUIRE.
  - TRACK, stable legal pair with value = (old+1) mod 60, where value = tens·10+units: load it and pulse `step_ok`.
  - TRACK, stable legal pair with any other value: load it, set `err_sequence`, stay in TRACK (resynchronise to the new value).
  - TRACK, stable illegal pair: set `err_pattern`, go to ACQUIRE. `units`/`tens` keep their last values.
- Timeout:
  - The cycle counter runs only in TRACK and clears on every accepted change and on entering TRACK.
  - On reaching TIMEOUT_CYCLES it sets `err_timeout` and saturates. The flag is not re-raised until a change clears the counter.
- Error flags are sticky until `clr_err`. If `clr_err` and a new error occur in the same cycle, the new error wins (the flag reads 1).
- Wrap-around: the change 59 → 00 counts as a correct step.

## Timing
- Reset values: `units`=0, `tens`=0, `value_valid`=0, `step_ok`=0, all `err_*`=0, FSM=IDLE, counters=0, `in_q`=0.
- Latency: if a new pattern is first captured into `in_q` at edge k and then held, the outputs update and `step_ok` pulses at edge k+STABLE_CYCLES. That is STABLE_CYCLES+1 edges after the pattern appears on the pins.
- Glitches shorter than STABLE_CYCLES samples are never accepted and never flagged.
- `value_valid` rises on the same edge the first value is loaded. It falls on the same edge as the illegal-pattern detection.
- `err_timeout` rises on the edge where the counter reaches TIMEOUT_CYCLES.
- An `rst` assertion mid-operation immediately forces all reset values (asynchronous). Operation resumes through IDLE/ACQUIRE after release.

## Test plan
- Test parameters: STABLE_CYCLES=2, TIMEOUT_CYCLES=20, SEG_ACTIVE_LOW=0.
- Drive 00 for 5 cycles, then 01, 02, … 59, 00, each held 6 cycles. Required: `value_valid`=1 after 00 is accepted; exactly 60 `step_ok` pulses; all errors 0; `tens`/`units` track the sequence.
- Hold 05, then apply a one-cycle 07 glitch, then 06. Required: no `err_sequence`, and a single `step_ok` for 06 at 2 edges after `in_q` captures 06.
- Go 12 → 15. Required: `err_sequence`=1, `units`=5; a following 16 gives `step_ok`. Then `clr_err` clears the flag.
- While tracking, drive tens pattern 1111101 (a 6). Required: `err_pattern`=1, `value_valid`=0, state ACQUIRE. Then 30 → reacquired without `err_sequence`.
- Hold 42 with no change. Required: `err_timeout` rises exactly 20 cycles after acceptance; assert `clr_err` on that same edge and the flag stays 1.
- Assert `rst` asynchronously mid-hold. Required: all outputs return to 0 without a clock edge.
